// File: rtl/fp_sum_sequencer.sv
// Sequences an operand stream through an external combinational FP adder,
// accumulating a running sum and reporting it with a valid/ready handshake.
module fp_sum_sequencer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             in_ready,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    output logic             add_bit,
    input  logic [31:0]      add_result,
    input  logic             add_overflow,
    output logic             sum_valid,
    input  logic             sum_ready,
    output logic [31:0]      sum_data,
    output logic             sum_overflow,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        FIRST,
        ACCUM,
        DONE
    } state_t;

    state_t           state;
    logic [31:0]      acc;
    logic [CNT_W-1:0] remaining;
    logic             ovf_sticky;
    logic             last_op;

    assign add_a        = acc;
    assign add_b        = in_data;
    assign add_bit      = 1'b1;
    assign sum_data     = acc;
    assign sum_overflow = ovf_sticky;
    assign last_op      = (remaining == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            acc        <= '0;
            remaining  <= '0;
            ovf_sticky <= 1'b0;
            in_ready   <= 1'b0;
            sum_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        acc        <= '0;
                        ovf_sticky <= 1'b0;
                        remaining  <= count;
                        busy       <= 1'b1;
                        if (count == '0) begin
                            state     <= DONE;
                            sum_valid <= 1'b1;
                        end else begin
                            state    <= FIRST;
                            in_ready <= 1'b1;
                        end
                    end
                end
                FIRST, ACCUM: begin
                    if (in_valid) begin
                        // the first operand seeds the accumulator without an add
                        if (state == FIRST) begin
                            acc <= in_data;
                        end else begin
                            acc        <= add_result;
                            ovf_sticky <= ovf_sticky | add_overflow;
                        end
                        remaining <= remaining - CNT_W'(1);
                        if (last_op) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            sum_valid <= 1'b1;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                DONE: begin
                    if (sum_ready) begin
                        state     <= IDLE;
                        sum_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_sum_sequencer.sv
// Scoreboard bench for fp_sum_sequencer with a behavioural FP adder
// for positive/negative normal values used by the directed vectors.
module tb_fp_sum_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  count = '0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_bit;
    logic [31:0] add_result;
    logic        add_overflow = 1'b0;
    logic        sum_valid;
    logic        sum_ready = 1'b1;
    logic [31:0] sum_data;
    logic        sum_overflow;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q[$];

    fp_sum_sequencer #(.CNT_W(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .count(count),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .add_a(add_a),
        .add_b(add_b),
        .add_bit(add_bit),
        .add_result(add_result),
        .add_overflow(add_overflow),
        .sum_valid(sum_valid),
        .sum_ready(sum_ready),
        .sum_data(sum_data),
        .sum_overflow(sum_overflow),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic real sp2r(input logic [31:0] x);
        real r;
        int  e;
        if (x[30:0] == '0) return 0.0;
        r = 1.0 + real'(x[22:0]) / 8388608.0;
        e = int'(x[30:23]) - 127;
        while (e > 0) begin r = r * 2.0; e--; end
        while (e < 0) begin r = r / 2.0; e++; end
        return x[31] ? -r : r;
    endfunction

    function automatic logic [31:0] r2sp(input real v);
        real  r;
        int   e;
        logic s;
        logic [22:0] m;
        if (v == 0.0) return 32'h0;
        s = (v < 0.0);
        r = s ? -v : v;
        e = 127;
        while (r >= 2.0) begin r = r / 2.0; e++; end
        while (r < 1.0) begin r = r * 2.0; e--; end
        m = 23'(longint'((r - 1.0) * 8388608.0));
        return {s, 8'(e), m};
    endfunction

    assign add_result = r2sp(sp2r(add_a) + sp2r(add_b));

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // scoreboard monitor: compares every accepted sum against the queue head
    always @(negedge clk) begin
        if (rst_n && sum_valid && sum_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_sum got %h/%b expected none",
                         sum_data, sum_overflow);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                if ({sum_overflow, sum_data} !== e) begin
                    errors++;
                    $display("FAIL sum got %h/%b expected %h/%b",
                             sum_data, sum_overflow, e[31:0], e[32]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [7:0] n);
        start = 1'b1;
        count = n;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input logic [31:0] d, input logic ovf);
        in_valid     = 1'b1;
        in_data      = d;
        add_overflow = ovf;
        tick();
        in_valid     = 1'b0;
        add_overflow = 1'b0;
    endtask

    task automatic outs_zero(input string name);
        chk(name, {in_ready, sum_valid, sum_data, sum_overflow, busy}, 64'h0);
    endtask

    initial begin
        #3;
        outs_zero("reset_outputs");
        chk("add_bit", add_bit, 1);
        #10 rst_n = 1'b1;
        tick();
        outs_zero("idle_after_reset");

        // 1.0 + 2.0 + 3.0 back to back
        exp_q.push_back({1'b0, 32'h40C00000});
        start_job(8'd3);
        chk("first_in_ready", in_ready, 1);
        feed(32'h3F800000, 1'b0);
        feed(32'h40000000, 1'b0);
        chk("add_a_is_acc", add_a, 32'h40400000);
        feed(32'h40400000, 1'b0);
        chk("sum_latency", {in_ready, sum_valid}, 2'b01);
        tick();
        chk("idle_after_sum", busy, 0);

        // zero-length job
        exp_q.push_back({1'b0, 32'h0});
        start_job(8'd0);
        chk("count0_done", {in_ready, sum_valid, sum_data}, {2'b01, 32'h0});
        tick();

        // single operand, adder unused
        exp_q.push_back({1'b0, 32'h41200000});
        start_job(8'd1);
        feed(32'h41200000, 1'b1);
        tick();

        // stalls on in_valid, then held sum
        exp_q.push_back({1'b0, 32'h41200000});
        start_job(8'd4);
        sum_ready = 1'b0;
        feed(32'h3F800000, 1'b0);
        tick();
        tick();
        chk("stall_acc", {busy, in_ready, add_a}, {2'b11, 32'h3F800000});
        feed(32'h40000000, 1'b0);
        feed(32'h40400000, 1'b0);
        tick();
        feed(32'h40800000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("hold_stable", {sum_valid, sum_data}, {1'b1, 32'h41200000});
            tick();
        end
        sum_ready = 1'b1;
        tick();
        chk("idle_after_hold", {busy, sum_valid}, 2'b00);

        // overflow on the second add only
        exp_q.push_back({1'b1, 32'h41200000});
        start_job(8'd4);
        feed(32'h3F800000, 1'b0);
        feed(32'h40000000, 1'b0);
        feed(32'h40400000, 1'b1);
        feed(32'h40800000, 1'b0);
        chk("ovf_sticky", sum_overflow, 1);
        tick();
        exp_q.push_back({1'b0, 32'h40000000});
        start_job(8'd2);
        chk("ovf_cleared", sum_overflow, 0);
        feed(32'h3F800000, 1'b0);
        feed(32'h3F800000, 1'b0);
        tick();

        // maximum count
        exp_q.push_back({1'b0, 32'h437F0000});
        start_job(8'd255);
        for (int i = 0; i < 254; i++) feed(32'h3F800000, 1'b0);
        chk("max_not_done", {in_ready, sum_valid}, 2'b10);
        feed(32'h3F800000, 1'b0);
        chk("max_done", {in_ready, sum_valid}, 2'b01);
        tick();

        // start ignored while accumulating
        exp_q.push_back({1'b0, 32'h40C00000});
        start_job(8'd3);
        feed(32'h3F800000, 1'b0);
        start_job(8'd1);
        feed(32'h40000000, 1'b0);
        chk("start_in_accum", {in_ready, sum_valid}, 2'b10);
        feed(32'h40400000, 1'b0);
        tick();

        // start ignored in DONE, including on the handshake cycle
        exp_q.push_back({1'b0, 32'h40000000});
        sum_ready = 1'b0;
        start_job(8'd1);
        feed(32'h40000000, 1'b0);
        start_job(8'd2);
        chk("start_in_done", {sum_valid, sum_data}, {1'b1, 32'h40000000});
        sum_ready = 1'b1;
        start_job(8'd2);
        chk("start_on_handshake", busy, 0);
        tick();

        // reset after 2 of 5 operands
        start_job(8'd5);
        feed(32'h3F800000, 1'b0);
        feed(32'h40000000, 1'b0);
        rst_n = 1'b0;
        #1;
        outs_zero("async_reset");
        chk("reset_acc", add_a, 32'h0);
        tick();
        rst_n = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("no_sum_after_reset", {sum_valid, in_ready, busy}, 3'b000);
        end
        in_valid = 1'b0;
        tick();

        chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fp_sum_sequencer.md
FP_SUM_SEQUENCER -- requirements
Module: fp_sum_sequencer

Interface
REQ-001 SHALL have parameter: CNT_W, 8, width of operand-count port.
REQ-002 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  one-cycle pulse; begins a summation job.
REQ-005 SHALL have port: count  input  CNT_W  number of operands in the job, sampled on start.
REQ-006 SHALL have port: in_valid  input  1  operand stream valid.
REQ-007 SHALL have port: in_data  input  32  IEEE-754 single operand.
REQ-008 SHALL have port: in_ready  output  1  operand accepted when in_valid and in_ready are both high.
REQ-009 SHALL have port: add_a  output  32  operand A to the combinational floating-point adder (accumulator).
REQ-010 SHALL have port: add_b  output  32  operand B to the adder (in_data, passed through).
REQ-011 SHALL have port: add_bit  output  1  hidden-bit input to the adder, tied to 1.
REQ-012 SHALL have port: add_result  input  32  adder sum, combinational from add_a/add_b.
REQ-013 SHALL have port: add_overflow  input  1  adder overflow flag.
REQ-014 SHALL have port: sum_valid  output  1  final sum available.
REQ-015 SHALL have port: sum_ready  input  1  consumer accepts the sum.
REQ-016 SHALL have port: sum_data  output  32  final sum.
REQ-017 SHALL have port: sum_overflow  output  1  sticky OR of add_overflow over the job.
REQ-018 SHALL have port: busy  output  1  high in any state other than IDLE.

Function
REQ-019 SHALL implement FSM states IDLE, FIRST, ACCUM, DONE.
REQ-020 In IDLE, start SHALL latch count into remaining counter and go to FIRST; if count==0 it SHALL go directly to DONE with acc=0x00000000 and sum_overflow=0.
REQ-021 In FIRST, in_ready=1; on handshake acc<=in_data (no add), remaining decrements; if remaining was 1 go to DONE, else go to ACCUM.
REQ-022 In ACCUM, in_ready=1; on handshake acc<=add_result, ovf_sticky<=ovf_sticky|add_overflow, remaining decrements; when remaining was 1 go to DONE.
REQ-023 Throughput SHALL be one operand per cycle; no bubble between back-to-back handshakes.
REQ-024 add_a SHALL equal acc and add_b SHALL equal in_data in every state; add_bit SHALL be 1 constantly.
REQ-025 in_ready SHALL be 0 in IDLE and DONE; in_valid in those states SHALL be ignored.
REQ-026 In DONE, sum_valid=1, sum_data=acc, sum_overflow=ovf_sticky, held stable until sum_valid&&sum_ready, then go to IDLE the next cycle.
REQ-027 start SHALL be ignored when not in IDLE; start in the same cycle as the DONE->IDLE handshake SHALL be ignored.
REQ-028 ovf_sticky SHALL clear on accepted start.
REQ-029 Counter SHALL be CNT_W bits, never wrap; count=2^CNT_W-1 SHALL accept exactly that many operands.
REQ-030 in_valid low SHALL stall FIRST/ACCUM indefinitely with acc, counter, ovf_sticky unchanged.

Reset
REQ-031 rst_n low SHALL asynchronously force IDLE, acc=0, counter=0, ovf_sticky=0, in_ready=0, sum_valid=0, sum_data=0, sum_overflow=0, busy=0.
REQ-032 Reset mid-job SHALL abandon the job; no sum_valid SHALL follow until a new start after release.

Verification
REQ-033 count=3, operands 0x3F800000,0x40000000,0x40400000 every cycle, adder model returns a+b -> sum_data=0x40C00000 (6.0), sum_valid 1 cycle after 3rd handshake, sum_overflow=0.
REQ-034 count=0 start -> next cycle DONE, sum_data=0x00000000, in_ready never high.
REQ-035 count=1, operand 0x41200000 -> sum_data=0x41200000, add_result unused.
REQ-036 count=4 with in_valid toggling 1,0,0,1,1,0,1 and sum_ready held 0 for 5 cycles -> sum stable whole hold, returns to IDLE one cycle after sum_ready.
REQ-037 adder model asserts add_overflow on 2nd add only -> sum_overflow=1 at DONE; next job with no overflow -> sum_overflow=0.
REQ-038 rst_n low after 2 of 5 operands -> all outputs zero immediately; start while in ACCUM/DONE ignored in separate run.
